// File: rtl/iomem_timer.sv
// iomem_timer
//   32-bit down-counting timer on the PicoSoC iomem bus, with an 8-bit
//   prescaler, one-shot and periodic modes, and a level interrupt.
//
//   Register map (iomem_addr[3:2]); iomem_addr[23:4] and [1:0] are don't-care:
//     0 CTRL   : [0] EN, [1] PERIODIC, [2] IRQ_EN, [15:8] PRESC
//     1 LOAD   : reload value
//     2 COUNT  : current count (a write loads the counter directly)
//     3 STATUS : [0] EXP, write-1-to-clear through byte lane 0
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   iomem_valid  bus request
//   iomem_ready  single-cycle acknowledge
//   iomem_wstrb  byte write strobes (0000 = read)
//   iomem_addr   byte address; [31:24] must equal ADDR_HI
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is high
//   irq          level interrupt, EXP & IRQ_EN
module iomem_timer #(
   parameter logic [7:0] ADDR_HI = 8'h04
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // Replace the byte lanes of old_v whose strobe is set with new_v.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return res;
   endfunction

   logic        en;
   logic        periodic;
   logic        irq_en;
   logic [7:0]  presc;
   logic [31:0] load;
   logic [31:0] count;
   logic        exp_flag;
   logic [7:0]  pc;

   logic        sel;
   logic        wr_any;
   logic [1:0]  reg_idx;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_count;
   logic        wr_status;
   logic [31:0] ctrl_val;
   logic [31:0] rd_val;
   logic        en_wr_clear;
   logic        tick_due;
   logic        tick;
   logic        unused_addr;

   assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
   assign reg_idx   = iomem_addr[3:2];
   assign wr_any    = sel && (iomem_wstrb != 4'b0000);
   assign wr_ctrl   = wr_any && (reg_idx == REG_CTRL);
   assign wr_load   = wr_any && (reg_idx == REG_LOAD);
   assign wr_count  = wr_any && (reg_idx == REG_COUNT);
   assign wr_status = wr_any && (reg_idx == REG_STATUS);

   // Aliased address bits are intentionally not decoded.
   assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

   assign ctrl_val = {16'h0000, presc, 5'b00000, irq_en, periodic, en};

   always_comb begin
      case (reg_idx)
         REG_CTRL:  rd_val = ctrl_val;
         REG_LOAD:  rd_val = load;
         REG_COUNT: rd_val = count;
         default:   rd_val = {31'h0, exp_flag};
      endcase
   end

   // A tick is dropped when the same cycle writes COUNT or writes EN=0.
   assign en_wr_clear = wr_ctrl && iomem_wstrb[0] && !iomem_wdata[0];
   assign tick_due    = en && (pc == presc);
   assign tick        = tick_due && !wr_count && !en_wr_clear;

   assign irq = exp_flag & irq_en;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         en          <= 1'b0;
         periodic    <= 1'b0;
         irq_en      <= 1'b0;
         presc       <= 8'h00;
         load        <= 32'h0;
         count       <= 32'h0;
         exp_flag    <= 1'b0;
         pc          <= 8'h00;
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'h0;
      end else begin
         iomem_ready <= sel;
         // Captured before this cycle's write lands, so reads see the old value.
         if (sel) iomem_rdata <= rd_val;

         // Any write of the EN lane restarts the prescaler phase.
         if (!en || tick_due || (wr_ctrl && iomem_wstrb[0])) pc <= 8'h00;
         else                                                pc <= pc + 8'd1;

         // Clear first so that an expiry in the same cycle overrides it.
         if (wr_status && iomem_wstrb[0] && iomem_wdata[0]) exp_flag <= 1'b0;

         if (tick) begin
            if (count != 32'd0) begin
               count <= count - 32'd1;
            end else begin
               exp_flag <= 1'b1;
               if (periodic) count <= load;
               else          en    <= 1'b0;
            end
         end

         // Bus writes come last so they take precedence over hardware updates.
         if (wr_ctrl) begin
            if (iomem_wstrb[0]) begin
               en       <= iomem_wdata[0];
               periodic <= iomem_wdata[1];
               irq_en   <= iomem_wdata[2];
            end
            if (iomem_wstrb[1]) presc <= iomem_wdata[15:8];
         end
         if (wr_load)  load  <= merge_bytes(load, iomem_wdata, iomem_wstrb);
         if (wr_count) count <= merge_bytes(count, iomem_wdata, iomem_wstrb);
      end
   end

endmodule

// File: tb/tb_iomem_timer.sv
// Testbench for iomem_timer: directed scenarios plus randomized timing runs
// checked against closed-form expectations for expiry times and counts.
module tb_iomem_timer;

   localparam logic [31:0] A_CTRL   = 32'h0400_0000;
   localparam logic [31:0] A_LOAD   = 32'h0400_0004;
   localparam logic [31:0] A_COUNT  = 32'h0400_0008;
   localparam logic [31:0] A_STATUS = 32'h0400_000C;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        irq;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] r_d;
   logic        r_ok;
   logic        r_one;
   int          r_lat;
   int          r_wc;

   iomem_timer #(.ADDR_HI(8'h04)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .irq         (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // One bus transaction; returns data, ack flag, edges to ack, whether ready
   // dropped on the following edge, and the cycle number of the ack edge.
   task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r, output logic ok, output int lat,
                      output logic one, output int wc);
      @(negedge clk);
      iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1;
      ok = 1'b0; r = 32'h0; lat = 0; one = 1'b0; wc = 0;
      while (!ok && lat < 4) begin
         @(posedge clk); #1;
         lat++;
         if (iomem_ready) begin ok = 1'b1; r = iomem_rdata; wc = cyc; end
      end
      iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      @(posedge clk); #1;
      one = !iomem_ready;
   endtask

   task automatic wrs(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      bus(a, s, d, r_d, r_ok, r_lat, r_one, r_wc);
      chk("write_ack", {31'h0, r_ok}, 32'h1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wrs(a, 4'hF, d);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      bus(a, 4'h0, 32'h0, r_d, r_ok, r_lat, r_one, r_wc);
      chk("read_ack", {31'h0, r_ok}, 32'h1);
      v = r_d;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   // Cycle number at which irq is first seen high, or -1 on timeout.
   task automatic wait_irq(input int limit, output int at);
      int n;
      n = 0; at = -1;
      while (!irq && n < limit) begin @(posedge clk); #1; n++; end
      if (irq) at = cyc;
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0]  lb [4];
      int e, at, at2;

      resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
      iomem_addr = 32'h0; iomem_wdata = 32'h0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
      chk("rst_rdata", iomem_rdata, 32'h0);
      chk("rst_irq",   {31'h0, irq}, 32'h0);

      // Read timing: ack one edge after valid, for exactly one cycle
      bus(A_CTRL, 4'h0, 32'h0, r_d, r_ok, r_lat, r_one, r_wc);
      chk("rd_latency", 32'(r_lat), 32'd1);
      chk("rd_pulse1",  {31'h0, r_one}, 32'h1);
      chk("rd_ctrl0",   r_d, 32'h0);

      // Periodic: LOAD=3, COUNT=3, PRESC=1 -> 8 cycles per expiry
      wr(A_LOAD, 32'd3); wr(A_COUNT, 32'd3);
      wr(A_CTRL, 32'h0000_0107);
      e = r_wc;
      wait_irq(100, at);
      chk("per_first_exp", 32'(at - e), 32'd8);
      rd(A_STATUS, v);
      chk("per_status", v, 32'h1);
      wr(A_STATUS, 32'h1);
      chk("per_irq_cleared", {31'h0, irq}, 32'h0);
      wait_irq(100, at2);
      chk("per_second_exp", 32'(at2 - at), 32'd8);
      wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h1);

      // One-shot: COUNT=2, PRESC=0 -> expiry after 3 cycles, EN drops
      wr(A_LOAD, 32'd0); wr(A_COUNT, 32'd2);
      wr(A_CTRL, 32'h0000_0005);
      e = r_wc;
      wait_irq(100, at);
      chk("os_exp", 32'(at - e), 32'd3);
      rd(A_CTRL, v);  chk("os_ctrl", v, 32'h4);
      rd(A_COUNT, v); chk("os_count", v, 32'h0);
      wr(A_STATUS, 32'h1);
      repeat (10) @(posedge clk);
      #1;
      chk("os_no_reexp", {31'h0, irq}, 32'h0);
      rd(A_STATUS, v); chk("os_status", v, 32'h0);

      // Byte strobes and address decode
      wr(A_LOAD, 32'h0);
      wrs(A_LOAD, 4'b0010, 32'hAABB_CCDD);
      rd(A_LOAD, v); chk("strb_load", v, 32'h0000_CC00);
      bus(32'h0500_0004, 4'hF, 32'h1234_5678, r_d, r_ok, r_lat, r_one, r_wc);
      chk("decode_no_ack", {31'h0, r_ok}, 32'h0);
      rd(32'h04FF_FFF4, v); chk("alias_load", v, 32'h0000_CC00);

      // Random byte-lane writes to LOAD against a per-byte model
      for (int i = 0; i < 4; i++) lb[i] = (i == 1) ? 8'hCC : 8'h00;
      for (int it = 0; it < 8; it++) begin
         logic [3:0]  s;
         logic [31:0] d;
         s = 4'($urandom_range(1, 15));
         d = $urandom;
         for (int i = 0; i < 4; i++) if (s[i]) lb[i] = d[i*8 +: 8];
         wrs(A_LOAD, s, d);
         rd(A_LOAD, v);
         chk("rand_strb_load", v, {lb[3], lb[2], lb[1], lb[0]});
      end

      // COUNT write on a tick edge wins; CTRL EN-clear on a tick edge drops it
      wr(A_COUNT, 32'd100);
      wr(A_CTRL, 32'h0000_0301);
      e = r_wc;
      wait_until(e + 5);
      rd(A_COUNT, v);  chk("col_pre_count", v, 32'd99);
      wait_until(e + 7);
      wr(A_COUNT, 32'h10);
      rd(A_COUNT, v);  chk("col_count_wins", v, 32'h10);
      rd(A_COUNT, v);  chk("col_count_hold", v, 32'h10);
      rd(A_COUNT, v);  chk("col_count_next", v, 32'h0F);
      wait_until(e + 15);
      wr(A_CTRL, 32'h0000_0300);
      rd(A_COUNT, v);  chk("col_en_clear_count", v, 32'h0F);
      rd(A_CTRL, v);   chk("col_en_clear_ctrl", v, 32'h0000_0300);

      // W1C of EXP on the expiry edge: set wins
      wr(A_COUNT, 32'd0); wr(A_STATUS, 32'h1);
      wr(A_CTRL, 32'h0000_0305);
      e = r_wc;
      wait_until(e + 3);
      wr(A_STATUS, 32'h1);
      chk("w1c_col_irq", {31'h0, irq}, 32'h1);
      rd(A_STATUS, v); chk("w1c_col_status", v, 32'h1);
      rd(A_CTRL, v);   chk("w1c_col_ctrl", v, 32'h0000_0304);
      wr(A_STATUS, 32'h1);
      rd(A_STATUS, v); chk("w1c_clear", v, 32'h0);

      // LOAD write on a periodic reload edge: reload uses the old LOAD
      wr(A_LOAD, 32'd5); wr(A_COUNT, 32'd0);
      wr(A_CTRL, 32'h0000_0303);
      e = r_wc;
      wait_until(e + 3);
      wr(A_LOAD, 32'd9);
      rd(A_COUNT, v); chk("reload_old_load", v, 32'd5);
      rd(A_LOAD, v);  chk("reload_new_load", v, 32'd9);
      wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h1);

      // Read-before-write on the same address
      wr(A_COUNT, 32'h77);
      bus(A_COUNT, 4'hF, 32'd5, r_d, r_ok, r_lat, r_one, r_wc);
      chk("rbw_old", r_d, 32'h77);
      rd(A_COUNT, v); chk("rbw_new", v, 32'd5);

      // Randomized periodic runs: closed-form expiry times and counts
      for (int it = 0; it < 6; it++) begin
         int n, p, l, t, per, rc, tk, w;
         n = int'($urandom_range(0, 20));
         p = int'($urandom_range(0, 3));
         l = int'($urandom_range(3, 10));
         t   = (n + 1) * (p + 1);
         per = (l + 1) * (p + 1);
         wr(A_LOAD, 32'(l)); wr(A_COUNT, 32'(n));
         wr(A_CTRL, 32'((p << 8) | 7));
         w = r_wc;
         if (t >= 4) begin
            rc = w + 2 + int'($urandom_range(0, 32'(t - 4)));
            wait_until(rc - 1);
            rd(A_COUNT, v);
            tk = (rc - 1 - w) / (p + 1);
            chk("rand_count", v, 32'(n - tk));
         end
         wait_irq(t + 50, at);
         chk("rand_first_exp", 32'(at - w), 32'(t));
         wr(A_STATUS, 32'h1);
         chk("rand_irq_cleared", {31'h0, irq}, 32'h0);
         wait_irq(per + 50, at2);
         chk("rand_period", 32'(at2 - at), 32'(per));
         wr(A_CTRL, 32'h0); wr(A_STATUS, 32'h1);
      end

      // Reset mid-count and mid-transaction
      wr(A_LOAD, 32'd50); wr(A_COUNT, 32'd0); wr(A_STATUS, 32'h1);
      wr(A_CTRL, 32'h0000_0007);
      chk("pre_rst_irq", {31'h0, irq}, 32'h1);
      rd(A_LOAD, v); chk("pre_rst_load", v, 32'd50);
      @(negedge clk);
      iomem_addr = A_CTRL; iomem_wstrb = 4'h0; iomem_valid = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_rdata", iomem_rdata, 32'h0);
      chk("mid_rst_ready", {31'h0, iomem_ready}, 32'h0);
      chk("mid_rst_irq",   {31'h0, irq}, 32'h0);
      @(posedge clk); #1;
      chk("mid_rst_no_ack", {31'h0, iomem_ready}, 32'h0);
      iomem_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      bus(A_CTRL, 4'h0, 32'h0, r_d, r_ok, r_lat, r_one, r_wc);
      chk("post_rst_latency", 32'(r_lat), 32'd1);
      chk("post_rst_pulse1",  {31'h0, r_one}, 32'h1);
      chk("post_rst_ctrl",    r_d, 32'h0);
      rd(A_LOAD, v);   chk("post_rst_load", v, 32'h0);
      rd(A_COUNT, v);  chk("post_rst_count", v, 32'h0);
      rd(A_STATUS, v); chk("post_rst_status", v, 32'h0);
      chk("post_rst_irq", {31'h0, irq}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
